// File: rtl/complement_unit_arbiter.sv
// Two-requester round-robin arbiter feeding a registered complement/pass unit.
// Fixed three-state sequence per transaction: IDLE -> EXEC -> DONE.
module complement_unit_arbiter #(
    parameter int NrOfBits = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Req_0,
    input  logic                Req_1,
    input  logic [NrOfBits-1:0] Data_0,
    input  logic [NrOfBits-1:0] Data_1,
    input  logic                Invert_0,
    input  logic                Invert_1,
    input  logic                Ack,
    output logic                Grant_0,
    output logic                Grant_1,
    output logic [NrOfBits-1:0] Result,
    output logic                Valid,
    output logic                Owner,
    output logic                Busy,
    output logic [7:0]          Count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic                ptr_q;
    logic                sel_q;
    logic                inv_q;
    logic [NrOfBits-1:0] op_q;
    logic [NrOfBits-1:0] result_q;
    logic                owner_q;
    logic                valid_q;
    logic                busy_q;
    logic                grant0_q;
    logic                grant1_q;
    logic [7:0]          count_q;

    logic                pick_d;
    logic                inv_d;
    logic [NrOfBits-1:0] op_d;

    // Contention goes to the pointer side; a lone request always wins.
    always_comb begin
        pick_d = (Req_0 && Req_1) ? ptr_q : Req_1;
        op_d   = pick_d ? Data_1 : Data_0;
        inv_d  = pick_d ? Invert_1 : Invert_0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            sel_q    <= 1'b0;
            inv_q    <= 1'b0;
            op_q     <= '0;
            result_q <= '0;
            owner_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Req_0 || Req_1) begin
                        state_q  <= EXEC;
                        sel_q    <= pick_d;
                        op_q     <= op_d;
                        inv_q    <= inv_d;
                        grant0_q <= ~pick_d;
                        grant1_q <= pick_d;
                        busy_q   <= 1'b1;
                    end
                end
                EXEC: begin
                    state_q  <= DONE;
                    result_q <= inv_q ? ~op_q : op_q;
                    owner_q  <= sel_q;
                    valid_q  <= 1'b1;
                    grant0_q <= 1'b0;
                    grant1_q <= 1'b0;
                end
                DONE: begin
                    if (Ack) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        count_q <= count_q + 8'd1;
                        ptr_q   <= ~owner_q;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    valid_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    grant0_q <= 1'b0;
                    grant1_q <= 1'b0;
                end
            endcase
        end
    end

    assign Grant_0 = grant0_q;
    assign Grant_1 = grant1_q;
    assign Result  = result_q;
    assign Valid   = valid_q;
    assign Owner   = owner_q;
    assign Busy    = busy_q;
    assign Count   = count_q;

endmodule
